// File: rtl/rand_gen_pkg.sv
// Shared constants and the Galois LFSR step function for the random source.
package rand_gen_pkg;

    localparam int unsigned LFSR_W_DEF = 16;
    localparam logic [15:0] TAPS_DEF   = 16'hB400;
    localparam logic [15:0] SEED_DEF   = 16'hACE1;

    // The step works on a wide container so any LFSR width up to STEP_W can
    // share it; callers zero-extend in and truncate out.
    localparam int unsigned STEP_W = 64;

    function automatic logic [STEP_W-1:0] lfsr_step(input logic [STEP_W-1:0] state,
                                                    input logic [STEP_W-1:0] taps);
        return (state >> 1) ^ (state[0] ? taps : '0);
    endfunction

endpackage

// File: rtl/lfsr_galois.sv
// Right-shifting Galois LFSR with synchronous seed load and lock-up recovery.
module lfsr_galois
    import rand_gen_pkg::*;
#(
    parameter int unsigned      W    = LFSR_W_DEF,
    parameter logic [W-1:0]     TAPS = TAPS_DEF,
    parameter logic [W-1:0]     SEED = SEED_DEF
) (
    input  logic         clk,
    input  logic         rst,
    output logic [W-1:0] state_o
);

    // An all-zero seed would lock the register, so it is replaced by 1.
    localparam logic [W-1:0] SEED_EFF = (SEED == '0) ? W'(1) : SEED;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_o <= SEED_EFF;
        end else if (state_o == '0) begin
            state_o <= SEED_EFF;
        end else begin
            state_o <= W'(lfsr_step(STEP_W'(state_o), STEP_W'(TAPS)));
        end
    end

endmodule

// File: rtl/rand_gen_3bit.sv
// Free-running 3-bit pseudo-random source: low bits of a 16-bit Galois LFSR.
module rand_gen_3bit
    import rand_gen_pkg::*;
#(
    parameter int unsigned          LFSR_W = LFSR_W_DEF,
    parameter logic [LFSR_W-1:0]    TAPS   = TAPS_DEF,
    parameter logic [LFSR_W-1:0]    SEED   = SEED_DEF
) (
    input  logic       system_clk,
    input  logic       rst,
    output logic [2:0] random
);

    logic [LFSR_W-1:0] state;

    lfsr_galois #(
        .W    (LFSR_W),
        .TAPS (TAPS),
        .SEED (SEED)
    ) u_lfsr (
        .clk     (system_clk),
        .rst     (rst),
        .state_o (state)
    );

    assign random = state[2:0];

    // Upper state bits only feed the LFSR itself.
    if (LFSR_W > 3) begin : g_upper
        logic [LFSR_W-4:0] upper_unused;
        assign upper_unused = state[LFSR_W-1:3];
    end

endmodule

// File: tb/tb_rand_gen_3bit.sv
// Self-checking bench for rand_gen_3bit against a behavioural LFSR model.
module tb_rand_gen_3bit;

    localparam logic [15:0] SEED  = 16'hACE1;
    localparam logic [15:0] TAPS  = 16'hB400;
    localparam int unsigned PERIOD = 65535;

    logic       clk;
    logic       rst;
    logic       rst0;
    logic [2:0] random;
    logic [2:0] random0;

    int vectors = 0;
    int errors  = 0;

    logic [15:0] m;
    bit          m_valid = 0;

    rand_gen_3bit dut (
        .system_clk (clk),
        .rst        (rst),
        .random     (random)
    );

    rand_gen_3bit #(
        .SEED (16'h0000)
    ) dut0 (
        .system_clk (clk),
        .rst        (rst0),
        .random     (random0)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_next(input logic [15:0] s);
        logic [15:0] t;
        if (s == 16'h0) return SEED;
        t = s / 2;
        if (s % 2 == 1) t = t ^ TAPS;
        return t;
    endfunction

    // Reference model advances on each edge from the inputs alone.
    always @(posedge clk) begin
        if (rst) begin
            m = SEED;
            m_valid = 1;
        end else if (m_valid) begin
            m = model_next(m);
        end
    end

    // Single compare process, sampling on the falling edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("model_random", {13'd0, random}, {13'd0, m[2:0]});
            check("model_state", dut.state, m);
        end
    end

    initial begin
        logic [2:0]  exp_seq [6];
        logic [15:0] exp_st  [6];
        int          hist    [8];
        bit          early_seed;
        bit          saw_zero;
        logic [15:0] s;

        exp_seq = '{3'd0, 3'd0, 3'd4, 3'd6, 3'd7, 3'd3};
        exp_st  = '{16'hE270, 16'h7138, 16'h389C, 16'h1C4E, 16'h0E27, 16'hB313};

        rst  = 1;
        rst0 = 0;
        repeat (2) @(posedge clk);
        #2;
        check("reset_state", dut.state, 16'hACE1);
        check("reset_random", {13'd0, random}, 16'd1);
        rst = 0;

        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #2;
            check("seq_random", {13'd0, random}, {13'd0, exp_seq[i]});
            check("seq_state", dut.state, exp_st[i]);
        end

        // Full period from a fresh seed.
        rst = 1;
        @(posedge clk); #2;
        rst = 0;
        for (int v = 0; v < 8; v++) hist[v] = 0;
        early_seed = 0;
        saw_zero   = 0;
        s          = '0;
        for (int i = 1; i <= int'(PERIOD); i++) begin
            @(posedge clk); #2;
            s = dut.state;
            if (i < int'(PERIOD) && s == SEED) early_seed = 1;
            if (s == 16'h0) saw_zero = 1;
            hist[random]++;
        end
        check("period_return", s, SEED);
        check("period_no_early_seed", {15'd0, early_seed}, 16'd0);
        check("period_no_zero", {15'd0, saw_zero}, 16'd0);
        for (int v = 0; v < 8; v++)
            check("hist", hist[v][15:0], (v == 0) ? 16'd8191 : 16'd8192);

        // Mid-run reset.
        repeat (1000) @(posedge clk);
        #2;
        rst = 1;
        @(posedge clk); #2;
        rst = 0;
        check("midrst_random", {13'd0, random}, 16'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #2;
            check("midrst_seq", {13'd0, random}, {13'd0, exp_seq[i]});
        end

        // Lock-up recovery: hold the register at zero, then let it run.
        repeat (20) @(posedge clk);
        #2;
        force dut.u_lfsr.state_o = 16'h0;
        m = 16'h0;
        @(negedge clk); #1;
        release dut.u_lfsr.state_o;
        @(posedge clk); #2;
        check("lockup_state", dut.state, 16'hACE1);
        check("lockup_random", {13'd0, random}, 16'd1);

        // Random reset pulses, checked by the model on every cycle.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #2;
            rst = ($urandom_range(0, 31) == 0);
        end
        rst = 0;

        // Zero-seed instance falls back to a seed of 1.
        rst0 = 1;
        @(posedge clk); #2;
        rst0 = 0;
        check("seed0_state", dut0.state, 16'h0001);
        check("seed0_random", {13'd0, random0}, 16'd1);
        @(posedge clk); #2;
        check("seed0_step_state", dut0.state, 16'hB400);
        check("seed0_step_random", {13'd0, random0}, 16'd0);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
